// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared scan-code, ASCII and FSM definitions for the keyboard path
package kb_pkg;

    // Set-2 make codes for the hex digits
    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;

    // Control keys and the break prefix the upstream extractor strips
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // ASCII bases and control characters
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_A   = 8'h41;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_ESC = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } kb_state_t;

endpackage

// File: rtl/key_ascii_queue_if.sv
// rtl/key_ascii_queue_if.sv - producer handshake and consumer FIFO port bundle
interface key_ascii_queue_if #(
    parameter int W = 2
);
    logic [7:0] key_code;
    logic       listo;
    logic       var_ack;
    logic       rd;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [W:0] count;
    logic       unk_tick;
    logic       ovf_tick;

    modport master (
        output key_code, listo, rd,
        input  var_ack, dout, empty, full, count, unk_tick, ovf_tick
    );

    modport slave (
        input  key_code, listo, rd,
        output var_ack, dout, empty, full, count, unk_tick, ovf_tick
    );
endinterface

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - small byte FIFO with registered head output
module key_fifo #(
    parameter int W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic [W:0] count
);
    localparam int         DEPTH     = 1 << W;
    localparam logic [W:0] DEPTH_CNT = (W + 1)'(DEPTH);

    logic [7:0]   mem [DEPTH];
    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic [W-1:0] rd_nxt;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr + W'(1);

    // Storage array: contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + W'(1);
            if (do_pop)  rd_ptr <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   count <= count + (W + 1)'(1);
                2'b01:   count <= count - (W + 1)'(1);
                default: count <= count;
            endcase
            // Head moves to the next stored entry, or to the incoming byte
            // when that byte becomes the only entry
            if (do_pop) begin
                if (count > (W + 1)'(1)) begin
                    dout <= mem[rd_nxt];
                end else if (do_push) begin
                    dout <= din;
                end
            end else if (do_push && empty) begin
                dout <= din;
            end
        end
    end
endmodule

// File: rtl/key_ascii_queue.sv
// rtl/key_ascii_queue.sv - scan-code capture, ASCII translation and queueing
module key_ascii_queue
    import kb_pkg::*;
#(
    parameter int W = 2
) (
    input  logic              clk,
    input  logic              reset,
    key_ascii_queue_if.slave  bus
);
    kb_state_t  state;
    kb_state_t  state_nxt;
    logic [7:0] code_reg;
    logic [7:0] ascii;
    logic       mapped;
    logic       ack;
    logic       push;
    logic       unk;
    logic       ovf;

    // State register; the code is latched on the IDLE->ACK transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            code_reg <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.listo) begin
                code_reg <= bus.key_code;
            end
        end
    end

    // Next state: RELEASE waits for listo to drop so one code is taken once
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.listo) state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_RELEASE;
            ST_RELEASE: if (!bus.listo) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Scan code to ASCII; anything not listed is unmapped
    always_comb begin
        mapped = 1'b1;
        ascii  = '0;
        case (code_reg)
            SC_0:     ascii = ASCII_0;
            SC_1:     ascii = ASCII_0 + 8'd1;
            SC_2:     ascii = ASCII_0 + 8'd2;
            SC_3:     ascii = ASCII_0 + 8'd3;
            SC_4:     ascii = ASCII_0 + 8'd4;
            SC_5:     ascii = ASCII_0 + 8'd5;
            SC_6:     ascii = ASCII_0 + 8'd6;
            SC_7:     ascii = ASCII_0 + 8'd7;
            SC_8:     ascii = ASCII_0 + 8'd8;
            SC_9:     ascii = ASCII_0 + 8'd9;
            SC_A:     ascii = ASCII_A;
            SC_B:     ascii = ASCII_A + 8'd1;
            SC_C:     ascii = ASCII_A + 8'd2;
            SC_D:     ascii = ASCII_A + 8'd3;
            SC_E:     ascii = ASCII_A + 8'd4;
            SC_F:     ascii = ASCII_A + 8'd5;
            SC_ENTER: ascii = ASCII_CR;
            SC_BKSP:  ascii = ASCII_BS;
            SC_ESC:   ascii = ASCII_ESC;
            default:  mapped = 1'b0;
        endcase
    end

    // Outputs: acknowledge always, push/drop/discard decided in ACK
    always_comb begin
        ack  = (state == ST_ACK);
        push = ack && mapped && (!bus.full || bus.rd);
        unk  = ack && !mapped;
        ovf  = ack && mapped && bus.full && !bus.rd;
    end

    assign bus.var_ack  = ack;
    assign bus.unk_tick = unk;
    assign bus.ovf_tick = ovf;

    key_fifo #(.W(W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (bus.rd),
        .din   (ascii),
        .dout  (bus.dout),
        .empty (bus.empty),
        .full  (bus.full),
        .count (bus.count)
    );
endmodule

// File: tb/tb_key_ascii_queue.sv
// tb/tb_key_ascii_queue.sv - randomized bench against a queue reference model
module tb_key_ascii_queue;
    localparam int W     = 2;
    localparam int DEPTH = 1 << W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_ascii_queue_if #(.W(W)) bus ();

    key_ascii_queue #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] q [$];

    logic [7:0] mapped_codes [19] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                      8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23,
                                      8'h24, 8'h2B, 8'h5A, 8'h66, 8'h76};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {mapped, ascii} from the key tables
    function automatic logic [8:0] ref_xlat(input logic [7:0] c);
        logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] hexl [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
        for (int i = 0; i < 10; i++) if (c == digits[i]) return {1'b1, 8'h30 + 8'(i)};
        for (int i = 0; i < 6; i++)  if (c == hexl[i])   return {1'b1, 8'h41 + 8'(i)};
        if (c == 8'h5A) return {1'b1, 8'h0D};
        if (c == 8'h66) return {1'b1, 8'h08};
        if (c == 8'h76) return {1'b1, 8'h1B};
        return 9'h000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
        chk({tag, ".full"},  32'(bus.full),  32'(q.size() == DEPTH));
        if (q.size() > 0) chk({tag, ".dout"}, 32'(bus.dout), 32'(q[0]));
    endtask

    task automatic send(input logic [7:0] code, input int hold, input bit rd_ack);
        logic [8:0] x;
        bit seen;
        int sz;
        seen = 1'b0;
        x = ref_xlat(code);
        bus.key_code = code;
        bus.listo    = 1'b1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.var_ack) seen = 1'b1;
        end
        chk("var_seen", 32'(seen), 32'd1);
        if (seen) begin
            sz = q.size();
            bus.rd = rd_ack;
            #1;
            chk("unk_tick", 32'(bus.unk_tick), 32'(!x[8]));
            chk("ovf_tick", 32'(bus.ovf_tick), 32'(x[8] && sz == DEPTH && !rd_ack));
            if (rd_ack && sz > 0) begin
                chk("ack_pop_dout", 32'(bus.dout), 32'(q[0]));
                void'(q.pop_front());
            end
            if (x[8] && (sz < DEPTH || rd_ack)) q.push_back(x[7:0]);
        end
        tick();
        bus.rd = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("var_once", 32'(bus.var_ack), 32'd0);
            tick();
        end
        bus.listo = 1'b0;
        tick();
        chk("var_idle", 32'(bus.var_ack), 32'd0);
        check_state("send");
    endtask

    task automatic pop_one();
        int sz;
        sz = q.size();
        if (sz > 0) chk("pop_dout", 32'(bus.dout), 32'(q[0]));
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        if (sz > 0) void'(q.pop_front());
        check_state("pop");
    endtask

    initial begin
        reset        = 1'b0;
        bus.listo    = 1'b1;
        bus.key_code = 8'h45;
        bus.rd       = 1'b0;

        // Held in reset with a pending code
        repeat (3) tick();
        chk("rst.var",  32'(bus.var_ack),  32'd0);
        chk("rst.unk",  32'(bus.unk_tick), 32'd0);
        chk("rst.ovf",  32'(bus.ovf_tick), 32'd0);
        chk("rst.dout", 32'(bus.dout),     32'd0);
        check_state("rst");

        reset = 1'b1;
        send(8'h45, 0, 1'b0);
        chk("first_dout", 32'(bus.dout), 32'h30);
        pop_one();

        // Ordered sequence, peak occupancy 3
        send(8'h16, 0, 1'b0);
        send(8'h1C, 1, 1'b0);
        send(8'h5A, 2, 1'b0);
        chk("peak_count", 32'(bus.count), 32'd3);
        repeat (3) pop_one();

        // Unmapped key
        send(8'h29, 0, 1'b0);
        chk("unk_empty", 32'(bus.empty), 32'd1);

        // Overflow and drain, then rd on empty
        foreach (mapped_codes[i]) if (i < 5) send(mapped_codes[i], 0, 1'b0);
        repeat (4) pop_one();
        pop_one();

        // Full with rd in the ACK cycle
        repeat (4) send(8'h3E, 0, 1'b0);
        send(8'h2E, 0, 1'b1);
        chk("full_rd_count", 32'(bus.count), 32'd4);
        repeat (4) pop_one();

        // Pointer wrap over push/pop pairs
        for (int i = 0; i < 10; i++) begin
            send(mapped_codes[i + 5], 0, 1'b0);
            pop_one();
        end

        // listo held long after the acknowledge
        send(8'h76, 20, 1'b0);
        pop_one();

        // Reset mid-operation discards entries
        send(8'h66, 0, 1'b0);
        send(8'h24, 0, 1'b0);
        bus.listo    = 1'b1;
        bus.key_code = 8'h32;
        tick();
        reset = 1'b0;
        #1;
        q.delete();
        chk("midrst.var", 32'(bus.var_ack), 32'd0);
        check_state("midrst");
        bus.listo = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            logic [7:0] c;
            if ($urandom_range(0, 2) < 2) begin
                if ($urandom_range(0, 1) == 1) c = mapped_codes[$urandom_range(0, 18)];
                else c = 8'($urandom_range(0, 255));
                send(c, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
            end else begin
                pop_one();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
